// File: rtl/cdnsusbhs_spram_arb_if.sv
// Bundle of the two requester ports, the single-port RAM side and the busy flag
// of the SPRAM arbiter. The slave modport is the arbiter; master is its environment.
interface cdnsusbhs_spram_arb_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
);
  // Port A: DMA engine, may lock the RAM for bursts
  logic                  a_req;
  logic                  a_we;
  logic                  a_lock;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_gnt;
  logic                  a_rvalid;
  logic [DATA_WIDTH-1:0] a_rdata;

  // Port B: register/CPU path
  logic                  b_req;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_gnt;
  logic                  b_rvalid;
  logic [DATA_WIDTH-1:0] b_rdata;

  // Single-port RAM
  logic                  mem_ce_n;
  logic                  mem_we_n;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;

  logic                  busy;

  modport slave (
    input  a_req, a_we, a_lock, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output mem_ce_n, mem_we_n, mem_addr, mem_din,
    input  mem_dout,
    output busy
  );

  modport master (
    output a_req, a_we, a_lock, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_ce_n, mem_we_n, mem_addr, mem_din,
    output mem_dout,
    input  busy
  );
endinterface

// File: rtl/cdnsusbhs_spram_arb.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM, with a
// burst lock for port A and a fixed 3-cycle read pipeline routed by port tags.
module cdnsusbhs_spram_arb #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_MAX  = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  cdnsusbhs_spram_arb_if.slave bus
);

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
    logic  read;
  } tag_t;

  localparam int              CNT_W      = 4;
  localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(BURST_MAX);
  localparam tag_t            TAG_IDLE   = '{valid: 1'b0, port: PORT_B, read: 1'b0};

  port_e                 last_gnt;
  logic [CNT_W-1:0]      lock_cnt;
  logic                  gnt_a;
  logic                  gnt_b;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  tag_t                  tag_s1;
  tag_t                  tag_s2;

  // ---------------------------------------------------------------------------
  // Arbitration: combinational from requests and registered lock/last-grant state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rstn) begin
      if (bus.a_req && bus.b_req) begin
        if (lock_cnt >= LOCK_LIMIT) begin
          gnt_b = 1'b1;
        end else if (bus.a_lock) begin
          gnt_a = 1'b1;
        end else if (last_gnt == PORT_B) begin
          gnt_a = 1'b1;
        end else begin
          gnt_b = 1'b1;
        end
      end else begin
        gnt_a = bus.a_req;
        gnt_b = bus.b_req;
      end
    end
  end

  assign bus.a_gnt = gnt_a;
  assign bus.b_gnt = gnt_b;

  always_comb begin
    sel_we    = bus.b_we;
    sel_addr  = bus.b_addr;
    sel_wdata = bus.b_wdata;
    if (gnt_a) begin
      sel_we    = bus.a_we;
      sel_addr  = bus.a_addr;
      sel_wdata = bus.a_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Lock counter and last-grant register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge value of the others, independent of block order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lock_cnt <= '0;
      last_gnt <= PORT_B;
    end else begin
      if (gnt_b) begin
        lock_cnt <= '0;
        last_gnt <= PORT_B;
      end else if (gnt_a) begin
        last_gnt <= PORT_A;
        if (!bus.a_lock)
          lock_cnt <= '0;
        else if (lock_cnt != LOCK_LIMIT)
          lock_cnt <= lock_cnt + 1'b1;
      end else if (!bus.a_lock) begin
        lock_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory access stage: registered RAM controls plus the first tag stage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.mem_ce_n <= 1'b1;
      bus.mem_we_n <= 1'b1;
      bus.mem_addr <= '0;
      bus.mem_din  <= '0;
      tag_s1       <= TAG_IDLE;
    end else if (gnt_a || gnt_b) begin
      bus.mem_ce_n <= 1'b0;
      bus.mem_we_n <= ~sel_we;
      bus.mem_addr <= sel_addr;
      bus.mem_din  <= sel_wdata;
      tag_s1       <= '{valid: 1'b1, port: (gnt_a ? PORT_A : PORT_B), read: ~sel_we};
    end else begin
      // Address and data are held so the RAM pins stay quiet between accesses
      bus.mem_ce_n <= 1'b1;
      bus.mem_we_n <= 1'b1;
      tag_s1       <= TAG_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // RAM-output stage and response capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_s2       <= TAG_IDLE;
      bus.a_rvalid <= 1'b0;
      bus.b_rvalid <= 1'b0;
      bus.a_rdata  <= '0;
      bus.b_rdata  <= '0;
    end else begin
      tag_s2       <= tag_s1;
      bus.a_rvalid <= 1'b0;
      bus.b_rvalid <= 1'b0;
      // mem_dout belongs to the access that sat in stage 1 one cycle earlier
      if (tag_s2.valid && tag_s2.read) begin
        if (tag_s2.port == PORT_A) begin
          bus.a_rvalid <= 1'b1;
          bus.a_rdata  <= bus.mem_dout;
        end else begin
          bus.b_rvalid <= 1'b1;
          bus.b_rdata  <= bus.mem_dout;
        end
      end
    end
  end

  assign bus.busy = tag_s1.valid | tag_s2.valid;

endmodule

// File: tb/tb_cdnsusbhs_spram_arb.sv
// Scoreboard bench for cdnsusbhs_spram_arb: directed stimulus queues expected
// grants and read responses; monitors compare them when the DUT presents them.
module tb_cdnsusbhs_spram_arb;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int BM = 4;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } rsp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;
  int   n_vec  = 0;
  int   n_miss = 0;

  rsp_t       a_q[$];
  rsp_t       b_q[$];
  logic [1:0] g_q[$];
  rsp_t       ra;
  rsp_t       rb;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] tbl [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cdnsusbhs_spram_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  cdnsusbhs_spram_arb #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .BURST_MAX (BM)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  // Synchronous single-port RAM: read data appears the cycle after the access
  always @(posedge clk) begin
    if (!bus.mem_ce_n) begin
      if (!bus.mem_we_n) ram[bus.mem_addr] <= bus.mem_din;
      else               bus.mem_dout      <= ram[bus.mem_addr];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Grant and response monitors
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.a_gnt || bus.b_gnt) begin
        if (g_q.size() == 0) check("gnt_unexpected", {bus.a_gnt, bus.b_gnt}, 2'b00);
        else                 check("gnt_order", {bus.a_gnt, bus.b_gnt}, g_q.pop_front());
      end
      if (bus.a_rvalid) begin
        if (a_q.size() == 0) begin
          check("a_rvalid_unexpected", bus.a_rvalid, 1'b0);
        end else begin
          ra = a_q.pop_front();
          check("a_rdata", bus.a_rdata, ra.data);
          check("a_latency", cyc, ra.cyc);
        end
      end
      if (bus.b_rvalid) begin
        if (b_q.size() == 0) begin
          check("b_rvalid_unexpected", bus.b_rvalid, 1'b0);
        end else begin
          rb = b_q.pop_front();
          check("b_rdata", bus.b_rdata, rb.data);
          check("b_latency", cyc, rb.cyc);
        end
      end
    end
  end

  task automatic idle();
    bus.a_req  = 1'b0;
    bus.b_req  = 1'b0;
    bus.a_lock = 1'b0;
    @(posedge clk); #1;
  endtask

  // Single-port access; returns one cycle after the grant so calls chain back-to-back
  task automatic access(input bit port_b, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                        input bit expect_rsp);
    int   waited = 0;
    logic gnt;
    rsp_t r;
    bus.a_lock = 1'b0;
    if (!port_b) begin
      bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
      bus.b_req = 1'b0;
    end else begin
      bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
      bus.a_req = 1'b0;
    end
    g_q.push_back(port_b ? 2'b01 : 2'b10);
    @(negedge clk);
    gnt = port_b ? bus.b_gnt : bus.a_gnt;
    while (!gnt && waited < 20) begin
      waited++;
      @(negedge clk);
      gnt = port_b ? bus.b_gnt : bus.a_gnt;
    end
    if (!gnt) begin
      check("gnt_timeout", gnt, 1'b1);
    end else if (!we && expect_rsp) begin
      r.data = exp_rdata;
      r.cyc  = cyc + 3;
      if (port_b) b_q.push_back(r);
      else        a_q.push_back(r);
    end
    @(posedge clk); #1;
  endtask

  // One cycle of both-port write traffic with the expected grant {a,b}
  task automatic drive_cycle(input bit ar, input bit br, input bit lk, input logic [1:0] exp);
    bus.a_req = ar; bus.a_we = 1'b1; bus.a_lock = lk; bus.a_addr = 7'h40; bus.a_wdata = 32'hAAAA_0000;
    bus.b_req = br; bus.b_we = 1'b1;                  bus.b_addr = 7'h41; bus.b_wdata = 32'hBBBB_0000;
    g_q.push_back(exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_miss);
    $fatal(1);
  end

  initial begin
    tbl[0] = 32'hDEAD_0000;
    tbl[1] = 32'hBEEF_0001;
    tbl[2] = 32'hCAFE_0002;
    tbl[3] = 32'hF00D_0003;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_lock = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b1; bus.b_we = 1'b0;                    bus.b_addr = '0; bus.b_wdata = '0;

    // Reset state, with both requests asserted to show grants are blocked
    repeat (3) @(negedge clk);
    check("rst_a_gnt",    bus.a_gnt,    1'b0);
    check("rst_b_gnt",    bus.b_gnt,    1'b0);
    check("rst_mem_ce_n", bus.mem_ce_n, 1'b1);
    check("rst_mem_we_n", bus.mem_we_n, 1'b1);
    check("rst_mem_addr", bus.mem_addr, 7'h00);
    check("rst_mem_din",  bus.mem_din,  32'h0);
    check("rst_rvalid",   {bus.a_rvalid, bus.b_rvalid}, 2'b00);
    check("rst_a_rdata",  bus.a_rdata,  32'h0);
    check("rst_b_rdata",  bus.b_rdata,  32'h0);
    check("rst_busy",     bus.busy,     1'b0);
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    idle();

    // Contention without lock: A,B,A,B,A,B
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, 1'b1, 1'b0, (i % 2) ? 2'b01 : 2'b10);
    idle();

    // Lock with BURST_MAX=4: A,A,A,A,B,A,A,A,A,B
    for (int i = 0; i < 10; i++) drive_cycle(1'b1, 1'b1, 1'b1, (i % 5 == 4) ? 2'b01 : 2'b10);
    idle();

    // Locked A alone past the limit, then B must win the first contended cycle
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b0, 1'b1, 2'b10);
    drive_cycle(1'b1, 1'b1, 1'b1, 2'b01);
    drive_cycle(1'b1, 1'b1, 1'b1, 2'b10);
    drive_cycle(1'b1, 1'b1, 1'b1, 2'b10);
    idle();

    // Single write then read on port A
    access(1'b0, 1'b1, 7'h05, 32'hA5A5_0001, 32'h0, 1'b0);
    idle();
    access(1'b0, 1'b0, 7'h05, 32'h0, 32'hA5A5_0001, 1'b1);
    repeat (5) idle();

    // Port B writes 0..3, then back-to-back reads
    for (int i = 0; i < 4; i++) access(1'b1, 1'b1, AW'(i), tbl[i], 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) access(1'b1, 1'b0, AW'(i), 32'h0, tbl[i], 1'b1);
    repeat (5) idle();
    check("a_rdata_hold", bus.a_rdata, 32'hA5A5_0001);

    // A writes 0x7F, B reads it on the very next grant
    access(1'b0, 1'b1, 7'h7F, 32'h1234_5678, 32'h0, 1'b0);
    access(1'b1, 1'b0, 7'h7F, 32'h0, 32'h1234_5678, 1'b1);
    repeat (5) idle();
    check("b_rdata_hold", bus.b_rdata, 32'h1234_5678);

    // Reset one cycle after a read grant: the read is discarded
    access(1'b1, 1'b0, 7'h02, 32'h0, 32'h0, 1'b0);
    bus.b_req = 1'b0;
    check("mid_mem_ce_n", bus.mem_ce_n, 1'b0);
    check("mid_busy",     bus.busy,     1'b1);
    rstn = 1'b0;
    #1;
    check("mid_rst_mem_ce_n", bus.mem_ce_n, 1'b1);
    check("mid_rst_mem_we_n", bus.mem_we_n, 1'b1);
    check("mid_rst_busy",     bus.busy,     1'b0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (6) idle();
    check("post_rst_busy", bus.busy, 1'b0);

    check("gnt_pending", g_q.size(), 0);
    check("a_pending",   a_q.size(), 0);
    check("b_pending",   b_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cdnsusbhs_spram_arb.md
CDNSUSBHS_SPRAM_ARB -- requirements
Module: cdnsusbhs_spram_arb

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 7, which is the RAM word-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, which is the data width of the RAM and of both ports.
REQ-003 The block SHALL have parameter BURST_MAX, default 4, which is the maximum number of consecutive locked grants to port A (legal range 1..15).
REQ-004 The block SHALL have these ports:
  clk  in  1  system clock, rising edge only.
  rstn  in  1  asynchronous active-low reset.
  a_req  in  1  port A (DMA engine) access request.
  a_we  in  1  port A write (1) / read (0).
  a_lock  in  1  port A requests back-to-back grants.
  a_addr  in  ADDR_WIDTH  port A word address.
  a_wdata  in  DATA_WIDTH  port A write data.
  a_gnt  out  1  port A request accepted this cycle.
  a_rvalid  out  1  port A read data valid, one-cycle pulse.
  a_rdata  out  DATA_WIDTH  port A read data.
  b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: port B (register/CPU path), same widths and meanings as port A; port B has no lock input.
  mem_ce_n  out  1  RAM chip enable, active low.
  mem_we_n  out  1  RAM write enable, active low.
  mem_addr  out  ADDR_WIDTH  RAM address.
  mem_din  out  DATA_WIDTH  RAM write data.
  mem_dout  in  DATA_WIDTH  RAM read data, valid in the cycle after a read is issued.
  busy  out  1  an access or read response is in flight.

Function
REQ-005 The block SHALL accept a request when x_gnt is high in the same cycle as x_req; a requester SHALL hold its request fields stable until it sees gnt.
REQ-006 The block SHALL grant at most one port per cycle; a_gnt and b_gnt SHALL never both be high.
REQ-007 Arbitration SHALL be combinational from the req inputs and registered state: with one requester, that requester is granted; with both, the port not granted most recently is granted (round-robin, last-grant register, reset value = B so A wins first).
REQ-008 Lock: when A is granted with a_lock=1, the lock counter SHALL increment; while the counter is below BURST_MAX and a_lock=1, A SHALL win over B.
REQ-009 When the lock counter reaches BURST_MAX, B SHALL win the next cycle in which both request; the counter SHALL clear on any B grant, on any A grant with a_lock=0, or on a cycle with no A grant and a_lock=0.
REQ-010 A grant in cycle N SHALL drive the registered mem_* outputs in cycle N+1: mem_ce_n=0, mem_we_n=~we, with address and data from the granted port; with no grant, mem_ce_n=1 and mem_we_n=1, and mem_addr/mem_din keep their last values.
REQ-011 For a read granted in cycle N, mem_dout SHALL be registered at the end of N+2, and x_rvalid SHALL pulse in N+3 with x_rdata; the access latency is a fixed 3 cycles.
REQ-012 x_rdata SHALL hold its value until the next x_rvalid for the same port.
REQ-013 Writes SHALL produce no rvalid.
REQ-014 A port-tag pipeline (2 stages, port ID plus read flag) SHALL route each response; grants on consecutive cycles SHALL be fully pipelined with throughput 1 access/cycle.
REQ-015 A read of an address written in the previous grant cycle SHALL return the new data (RAM order is preserved and there is no bypass).
REQ-016 busy SHALL be high when any pipeline stage (mem access stage or tag stages) is valid.

Reset
REQ-017 On rstn=0 the block SHALL asynchronously set: mem_ce_n=1, mem_we_n=1, mem_addr=0, mem_din=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, busy=0, pipeline tags invalid, lock counter=0, last-grant=B.
REQ-018 The gnt outputs SHALL be 0 while rstn=0.
REQ-019 Accesses in flight when reset asserts SHALL be discarded, and no rvalid SHALL follow reset release.

Verification
REQ-020 Single read: write A addr 0x05 data 0xA5A5_0001, then read A 0x05 -> a_rvalid 3 cycles after gnt with a_rdata=0xA5A5_0001, and b_rvalid stays 0.
REQ-021 Contention: a_req and b_req held high for 6 cycles with a_lock=0 -> grants alternate A,B,A,B,A,B.
REQ-022 Lock: BURST_MAX=4, a_lock=1, a_req and b_req held high -> A,A,A,A,B,A,A,A,A,B.
REQ-023 Back-to-back reads: B reads 0x00..0x03 on consecutive grants -> four consecutive b_rvalid pulses with data in order.
REQ-024 Reset mid-read: rstn asserted 1 cycle after a read grant -> no rvalid, mem_ce_n=1 immediately, busy=0.
REQ-025 Write-then-read same cycle pair: A writes 0x7F=0x1234_5678 at N, B reads 0x7F at N+1 -> b_rdata=0x1234_5678.
